i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_sync_edge.sv | 43 ++++
 rtl/i2c_slave_rx.sv | 153 +++++++++++++++
 tb/tb_i2c_slave_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C write-only target receiver.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-flop synchronizer plus rise/fall detect for one bus line; idle level is 1.
// I2C_SLAVE_RX_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 clk latency).
module i2c_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_lvl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_raw};
  end

`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
  logic [2:0] r_samp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_samp <= 3'b111;
    else          r_samp <= {r_samp[1:0], r_sync[1]};
  end

  assign w_lvl = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
`else
  assign w_lvl = r_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= 1'b1;
    else          r_prev <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: address match, ACK generation, byte receive, START/STOP tracking.
// Optional glitch filter on SCL/SDA via I2C_SLAVE_RX_GLITCH_FILTER_EN (see i2c_sync_edge).
module i2c_slave_rx
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] own_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              addr_match,
  output logic              stop_det
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_sync_edge u_scl (
    .clk    (clk),
    .reset_n(reset_n),
    .i_raw  (scl_in),
    .o_lvl  (w_scl_lvl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk    (clk),
    .reset_n(reset_n),
    .i_raw  (sda_in),
    .o_lvl  (w_sda_lvl),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [DATA_W-2:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_match, w_match_nxt;
  logic              r_stop_det, w_stop_det_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic [DATA_W-1:0] w_byte;

  assign w_byte = {r_shift, w_sda_lvl};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // STOP outranks START, which outranks any SCL edge handling.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_match_nxt    = r_match;
    w_stop_det_nxt = 1'b0;
    w_sda_oe_nxt   = r_sda_oe;
    if (w_stop) begin
      w_state_nxt    = ST_IDLE;
      w_cnt_nxt      = 3'd0;
      w_busy_nxt     = 1'b0;
      w_match_nxt    = 1'b0;
      w_sda_oe_nxt   = 1'b0;
      w_stop_det_nxt = 1'b1;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 3'd0;
      w_busy_nxt   = 1'b1;
      w_match_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[DATA_W-2:0];
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_state == ST_ADDR) begin
                if (w_byte == {own_addr, RW_WRITE}) begin
                  w_state_nxt = ST_ADDR_ACK;
                  w_match_nxt = 1'b1;
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end else begin
                w_rx_data_nxt  = w_byte;
                w_rx_valid_nxt = 1'b1;
                w_state_nxt    = ST_DATA_ACK;
              end
            end
          end
        end
        // First fall after the byte drives ACK; the following fall releases it.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            if (r_sda_oe) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_DATA;
            end else begin
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 3'd0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_match    <= 1'b0;
      r_stop_det <= 1'b0;
      r_sda_oe   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_match    <= w_match_nxt;
      r_stop_det <= w_stop_det_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
    end
  end

  assign sda_oe     = r_sda_oe;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign busy       = r_busy;
  assign addr_match = r_match;
  assign stop_det   = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master with an open-drain SDA model.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [6:0] own_addr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       addr_match;
  logic       stop_det;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_m),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .own_addr  (own_addr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .addr_match(addr_match),
    .stop_det  (stop_det)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] rxq[$];
  int stop_cnt = 0;
  int oe_bad = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxq.push_back(rx_data);
    if (stop_det === 1'b1) stop_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clks(10);
    sda_m = 1'b0;
    wait_clks(10);
    scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_clks(3);
    sda_m = 1'b1;
    wait_clks(7);
    scl_m = 1'b1;
    wait_clks(10);
    sda_m = 1'b0;
    wait_clks(10);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clks(3);
    sda_m = 1'b0;
    wait_clks(7);
    scl_m = 1'b1;
    wait_clks(10);
    sda_m = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_bit(input logic b);
    wait_clks(3);
    sda_m = b;
    wait_clks(7);
    scl_m = 1'b1;
    wait_clks(5);
    if (sda_oe !== 1'b0) oe_bad++;
    wait_clks(5);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clks(3);
    sda_m = 1'b1;
    wait_clks(7);
    scl_m = 1'b1;
    wait_clks(5);
    ack = sda_oe;
    wait_clks(5);
    scl_m = 1'b0;
  endtask

  typedef struct {
    logic [6:0]      own;
    logic [7:0]      abyte;
    int              ndata;
    logic [2:0][7:0] d;
    logic            exp_ack;
    int              exp_nvalid;
    logic            exp_match;
    state_t          exp_state;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       ack;
    logic [7:0] pbyte;
    int         s0;

    vecs[0] = '{own:7'h42, abyte:8'h84, ndata:1, d:{8'h00, 8'h00, 8'hA5},
                exp_ack:1'b1, exp_nvalid:1, exp_match:1'b1, exp_state:ST_DATA};
    vecs[1] = '{own:7'h42, abyte:8'h86, ndata:1, d:{8'h00, 8'h00, 8'hA5},
                exp_ack:1'b0, exp_nvalid:0, exp_match:1'b0, exp_state:ST_IGNORE};
    vecs[2] = '{own:7'h42, abyte:8'h85, ndata:1, d:{8'h00, 8'h00, 8'hA5},
                exp_ack:1'b0, exp_nvalid:0, exp_match:1'b0, exp_state:ST_IGNORE};
    vecs[3] = '{own:7'h42, abyte:8'h84, ndata:3, d:{8'h00, 8'hFF, 8'h3C},
                exp_ack:1'b1, exp_nvalid:3, exp_match:1'b1, exp_state:ST_DATA};
    vecs[4] = '{own:7'h15, abyte:8'h2A, ndata:2, d:{8'h00, 8'h80, 8'h01},
                exp_ack:1'b1, exp_nvalid:2, exp_match:1'b1, exp_state:ST_DATA};

    reset_n  = 1'b0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    own_addr = 7'h42;
    wait_clks(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr_match", addr_match, 1'b0);
    check("rst_stop_det", stop_det, 1'b0);
    check("rst_state", dut.r_state, ST_IDLE);
    reset_n = 1'b1;
    wait_clks(5);

    for (int v = 0; v < 5; v++) begin
      own_addr = vecs[v].own;
      rxq.delete();
      oe_bad = 0;
      s0 = stop_cnt;
      bus_start();
      wait_clks(8);
      check("busy_after_start", busy, 1'b1);
      send_byte(vecs[v].abyte, ack);
      check("addr_ack", ack, vecs[v].exp_ack);
      for (int k = 0; k < vecs[v].ndata; k++) begin
        send_byte(vecs[v].d[k], ack);
        check("data_ack", ack, vecs[v].exp_ack);
      end
      wait_clks(8);
      check("busy_before_stop", busy, 1'b1);
      check("addr_match", addr_match, vecs[v].exp_match);
      check("state_before_stop", dut.r_state, vecs[v].exp_state);
      check("oe_during_bits", oe_bad, 0);
      bus_stop();
      wait_clks(5);
      check("rx_count", rxq.size(), vecs[v].exp_nvalid);
      for (int k = 0; k < vecs[v].exp_nvalid && k < rxq.size(); k++)
        check("rx_data", rxq[k], vecs[v].d[k]);
      check("stop_det_pulses", stop_cnt - s0, 1);
      check("busy_after_stop", busy, 1'b0);
      check("match_after_stop", addr_match, 1'b0);
      check("oe_after_stop", sda_oe, 1'b0);
    end

    // Repeated START after a partial byte: the partial byte must be discarded.
    own_addr = 7'h42;
    rxq.delete();
    bus_start();
    send_byte(8'h84, ack);
    check("rs_addr_ack1", ack, 1'b1);
    pbyte = 8'hA0;
    for (int i = 7; i >= 4; i--) send_bit(pbyte[i]);
    bus_rstart();
    wait_clks(8);
    check("rs_state", dut.r_state, ST_ADDR);
    check("rs_busy", busy, 1'b1);
    send_byte(8'h84, ack);
    check("rs_addr_ack2", ack, 1'b1);
    send_byte(8'h5A, ack);
    check("rs_data_ack", ack, 1'b1);
    bus_stop();
    wait_clks(5);
    check("rs_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("rs_rx_data", rxq[0], 8'h5A);

    // Reset asserted while the target is driving the data ACK.
    rxq.delete();
    bus_start();
    send_byte(8'h84, ack);
    pbyte = 8'hC3;
    for (int i = 7; i >= 0; i--) send_bit(pbyte[i]);
    wait_clks(3);
    sda_m = 1'b1;
    wait_clks(6);
    check("ack_driven", sda_oe, 1'b1);
    check("ack_state", dut.r_state, ST_DATA_ACK);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sda_oe", sda_oe, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_addr_match", addr_match, 1'b0);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_stop_det", stop_det, 1'b0);
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(3);
    send_byte(8'h84, ack);
    check("no_start_ack", ack, 1'b0);
    check("no_start_busy", busy, 1'b0);
    wait_clks(3);
    sda_m = 1'b1;
    wait_clks(7);
    scl_m = 1'b1;
    rxq.delete();
    bus_start();
    send_byte(8'h84, ack);
    check("resume_addr_ack", ack, 1'b1);
    send_byte(8'hA5, ack);
    check("resume_data_ack", ack, 1'b1);
    bus_stop();
    wait_clks(5);
    check("resume_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("resume_rx_data", rxq[0], 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
